// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: serial duty load, then one or repeated PWM periods.
// Latency: the first RUN cycle follows STAGE cycles after start (counting the start cycle as 0).
// Outputs come from registers fed by next-state logic, so out/hsync line up with the current count.
// No backpressure: start is only taken in IDLE and ignored while LOAD or RUN is active.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   start, data    load strobe and serial duty words (channel 0 arrives with start)
//   center         alignment mode, sampled with start (1 = center-aligned)
//   repeat_en      sampled at period end: 1 = run another period, 0 = return to IDLE
//   out            PWM outputs, one bit per channel
//   hsync          pulse on the first cycle of each period
//   busy           high in LOAD and RUN
//   done           pulse on the first IDLE cycle after the last period
module pwm_multi_gen #(
    parameter int STAGE  = 8,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] data,
    input  logic              center,
    input  logic              repeat_en,
    output logic [STAGE-1:0]  out,
    output logic              hsync,
    output logic              busy,
    output logic              done
);

    localparam int IW = (STAGE > 1) ? $clog2(STAGE) : 1;
    // The period is 2^DWIDTH - 1 clocks, so the count runs 0 .. 2^DWIDTH - 2.
    localparam logic [DWIDTH-1:0] PERIOD = '1;
    localparam logic [DWIDTH-1:0] CNT_MAX = PERIOD - 1'b1;
    localparam logic [IW-1:0]     LAST_IDX = IW'(STAGE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [DWIDTH-1:0] cnt, cnt_nxt;
    logic [DWIDTH-1:0] duty     [STAGE];
    logic [DWIDTH-1:0] duty_nxt [STAGE];
    logic              center_q, center_nxt;
    logic [STAGE-1:0]  out_nxt;

    // Next-state logic. The registered outputs are computed from these
    // next values, so the out value for a count shows up in the same cycle
    // as that count, including the last duty word captured on RUN entry.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        center_nxt = center_q;
        duty_nxt   = duty;
        case (state)
            IDLE: begin
                if (start) begin
                    duty_nxt[0] = data;
                    center_nxt  = center;
                    idx_nxt     = IW'(1);
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                duty_nxt[idx] = data;
                idx_nxt       = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_MAX) begin
                    cnt_nxt = '0;
                    if (!repeat_en) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-channel compare. Center mode places the pulse at
    // s = (P - duty) / 2; the upper bound is taken one bit wider so
    // s + duty never wraps.
    always_comb begin
        out_nxt = '0;
        for (int k = 0; k < STAGE; k++) begin
            logic [DWIDTH-1:0] s;
            logic [DWIDTH:0]   hi;
            s  = (PERIOD - duty_nxt[k]) >> 1;
            hi = {1'b0, s} + {1'b0, duty_nxt[k]};
            if (state_nxt == RUN) begin
                if (center_nxt) begin
                    out_nxt[k] = (cnt_nxt >= s) && ({1'b0, cnt_nxt} < hi);
                end else begin
                    out_nxt[k] = (cnt_nxt < duty_nxt[k]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            center_q <= 1'b0;
            for (int k = 0; k < STAGE; k++) begin
                duty[k] <= '0;
            end
            out      <= '0;
            hsync    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            center_q <= center_nxt;
            duty     <= duty_nxt;
            out      <= out_nxt;
            // The count only sits at zero inside RUN on entry or on a wrap.
            hsync    <= (state_nxt == RUN) && (cnt_nxt == '0);
            busy     <= (state_nxt != IDLE);
            done     <= (state == RUN) && (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Randomized self-checking bench for pwm_multi_gen with a cycle-level reference model.
// The model derives expected outputs from the cycle offset after start using period arithmetic.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_pwm_multi_gen;

    localparam int STAGE  = 8;
    localparam int DWIDTH = 8;
    localparam int P      = (1 << DWIDTH) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DWIDTH-1:0] data;
    logic              center;
    logic              repeat_en;
    logic [STAGE-1:0]  out;
    logic              hsync;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    pwm_multi_gen #(.STAGE(STAGE), .DWIDTH(DWIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data      (data),
        .center    (center),
        .repeat_en (repeat_en),
        .out       (out),
        .hsync     (hsync),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pulse shape taken directly from the duty and alignment rules.
    function automatic bit ref_bit(input int c, input int d, input bit ctr);
        int s;
        if (!ctr) return (c < d);
        s = (P - d) / 2;
        return (c >= s) && (c < s + d);
    endfunction

    task automatic idle_cycle(input bit exp_done);
        @(negedge clk);
        chk("idle_done", 32'(done), 32'(exp_done));
        chk("idle_busy", 32'(busy), 0);
        chk("idle_out", 32'(out), 0);
        chk("idle_hsync", 32'(hsync), 0);
        start     = 1'b0;
        repeat_en = 1'b0;
    endtask

    // Drives one load plus nper periods. The first falling edge is the start
    // cycle; exp_done says whether that cycle should carry the done pulse from
    // the previous burst. A non-negative abort_at asserts rst at that RUN cycle.
    task automatic burst(input logic [DWIDTH-1:0] d [STAGE], input bit ctr,
                         input int nper, input bit exp_done, input int abort_at);
        int hi [STAGE];
        logic [STAGE-1:0] exp_out;
        int c;
        for (int k = 0; k < STAGE; k++) hi[k] = 0;

        @(negedge clk);
        chk("c0_done", 32'(done), 32'(exp_done));
        chk("c0_busy", 32'(busy), 0);
        chk("c0_out", 32'(out), 0);
        start     = 1'b1;
        data      = d[0];
        center    = ctr;
        repeat_en = 1'($urandom);

        for (int t = 1; t < STAGE; t++) begin
            @(negedge clk);
            chk("load_busy", 32'(busy), 1);
            chk("load_out", 32'(out), 0);
            chk("load_hsync", 32'(hsync), 0);
            chk("load_done", 32'(done), 0);
            start  = 1'($urandom);
            data   = d[t];
            center = 1'($urandom);
        end

        for (int r = 0; r < nper * P; r++) begin
            @(negedge clk);
            c = r % P;
            for (int k = 0; k < STAGE; k++) exp_out[k] = ref_bit(c, int'(d[k]), ctr);
            chk("run_out", 32'(out), 32'(exp_out));
            chk("run_hsync", 32'(hsync), 32'(c == 0));
            chk("run_busy", 32'(busy), 1);
            chk("run_done", 32'(done), 0);
            for (int k = 0; k < STAGE; k++) hi[k] += int'(out[k]);
            if (r == abort_at) begin
                start = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("rst_out", 32'(out), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_hsync", 32'(hsync), 0);
                return;
            end
            start  = ($urandom_range(0, 7) == 0);
            data   = DWIDTH'($urandom);
            center = 1'($urandom);
            // repeat_en only matters on the last count, so its value elsewhere is random.
            if (c == P - 1) repeat_en = (r / P < nper - 1);
            else            repeat_en = 1'($urandom);
        end
        start     = 1'b0;
        repeat_en = 1'b0;
        for (int k = 0; k < STAGE; k++) chk("high_count", 32'(hi[k]), 32'(nper * int'(d[k])));
    endtask

    logic [DWIDTH-1:0] dv [STAGE];
    bit prev_done;

    initial begin
        rst = 1'b1; start = 1'b0; data = '0; center = 1'b0; repeat_en = 1'b0;
        #1;
        chk("reset_out", 32'(out), 0);
        chk("reset_hsync", 32'(hsync), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_cycle(1'b0);

        // Left-aligned ramp 0..7
        for (int k = 0; k < STAGE; k++) dv[k] = DWIDTH'(k);
        burst(dv, 1'b0, 1, 1'b0, -1);
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Extremes
        for (int k = 0; k < STAGE; k++) dv[k] = 8'h80;
        dv[0] = 8'h00; dv[1] = 8'hFF;
        burst(dv, 1'b0, 1, 1'b0, -1);
        idle_cycle(1'b1);

        // Center-aligned
        for (int k = 0; k < STAGE; k++) dv[k] = DWIDTH'($urandom);
        dv[2] = 8'h04; dv[3] = 8'h05; dv[4] = 8'hFF; dv[5] = 8'h00;
        burst(dv, 1'b1, 1, 1'b0, -1);
        idle_cycle(1'b1);

        // Repeat mode with a full-duty channel, then a back-to-back reload
        for (int k = 0; k < STAGE; k++) dv[k] = DWIDTH'($urandom);
        dv[1] = 8'hFF;
        burst(dv, 1'b0, 3, 1'b0, -1);
        for (int k = 0; k < STAGE; k++) dv[k] = DWIDTH'($urandom);
        burst(dv, 1'b1, 1, 1'b1, -1);
        idle_cycle(1'b1);

        // Reset at cnt 50, then a fresh load of 3s
        for (int k = 0; k < STAGE; k++) dv[k] = 8'hC0;
        burst(dv, 1'b0, 1, 1'b0, 50);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < STAGE; k++) dv[k] = 8'h03;
        burst(dv, 1'b0, 1, 1'b0, -1);
        idle_cycle(1'b1);

        // Random bursts, sometimes chained back-to-back
        prev_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < STAGE; k++) begin
                case ($urandom_range(0, 5))
                    0:       dv[k] = 8'h00;
                    1:       dv[k] = 8'hFF;
                    default: dv[k] = DWIDTH'($urandom);
                endcase
            end
            burst(dv, 1'($urandom), int'($urandom_range(1, 2)), prev_done, -1);
            if ($urandom_range(0, 1) == 1) begin
                prev_done = 1'b1;
            end else begin
                idle_cycle(1'b1);
                prev_done = 1'b0;
            end
        end
        if (prev_done) idle_cycle(1'b1);
        idle_cycle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
